// File: rtl/cpu.sv
// 8-bit accumulator CPU with 16-bit address bus and on-chip RAM.
// A T-state sequencer fetches byte-coded instructions from address 0
// after reset. The bus nets are plain wires so debug tooling can force them.
module cpu #(
  parameter int MEMORY_DEPTH = 256
) (
  input logic clk,
  input logic reset,
  input logic hlt
);

  wire [15:0] address_bus;
  wire [7:0]  data_bus;
  wire        OE_M;
  wire        WE_M;
  wire [7:0]  cpu_wdata;
  wire [7:0]  ram_rdata;

  // The CPU owns the data bus while writing and the RAM owns it while reading.
  // With neither strobe active the bus reads as zero.
  assign data_bus = WE_M ? cpu_wdata : (OE_M ? ram_rdata : 8'h00);

  if (1'b1) begin : control_unit
    localparam logic [1:0] T0 = 2'd0;
    localparam logic [1:0] T1 = 2'd1;
    localparam logic [1:0] T2 = 2'd2;
    localparam logic [1:0] T3 = 2'd3;

    localparam logic [7:0] OP_MVIA  = 8'h10;
    localparam logic [7:0] OP_MVIB  = 8'h11;
    localparam logic [7:0] OP_LDA   = 8'h20;
    localparam logic [7:0] OP_STA   = 8'h21;
    localparam logic [7:0] OP_ADD   = 8'h30;
    localparam logic [7:0] OP_SUB   = 8'h31;
    localparam logic [7:0] OP_AND   = 8'h32;
    localparam logic [7:0] OP_OR    = 8'h33;
    localparam logic [7:0] OP_XOR   = 8'h34;
    localparam logic [7:0] OP_NOT   = 8'h35;
    localparam logic [7:0] OP_MOVBA = 8'h40;
    localparam logic [7:0] OP_MOVAB = 8'h41;
    localparam logic [7:0] OP_JMP   = 8'h50;
    localparam logic [7:0] OP_JZ    = 8'h51;
    localparam logic [7:0] OP_JC    = 8'h52;
    localparam logic [7:0] OP_HLT   = 8'hFF;

    logic [7:0]  a_q, a_d, b_q, b_d, ir_q, ir_d, tmp_q, tmp_d;
    logic [15:0] pc_q, pc_d, mar_q, mar_d;
    logic        z_q, z_d, c_q, c_d;
    logic [1:0]  t_q, t_d;
    logic        HLT;
    logic        hlt_latch_d;
    logic        en_timer;

    logic [15:0] addr_s;
    logic        oe_s, we_s;
    logic [7:0]  wdata_s;
    logic [8:0]  alu_s;
    logic        is_mvi_s, is_mem_s, is_jmp_s, jump_taken_s;

    // Everything advances only when out of reset, not stalled and not halted.
    assign en_timer = reset & ~hlt & ~HLT;

    assign is_mvi_s = (ir_q == OP_MVIA) | (ir_q == OP_MVIB);
    assign is_mem_s = (ir_q == OP_LDA) | (ir_q == OP_STA);
    assign is_jmp_s = (ir_q == OP_JMP) | (ir_q == OP_JZ) | (ir_q == OP_JC);
    assign jump_taken_s = (ir_q == OP_JMP) | ((ir_q == OP_JZ) & z_q) | ((ir_q == OP_JC) & c_q);

    assign address_bus = addr_s;
    assign OE_M        = oe_s;
    assign WE_M        = we_s;
    assign cpu_wdata   = wdata_s;

    // Bus strobes and address depend only on state, never on the data bus.
    always_comb begin
      addr_s  = 16'h0000;
      oe_s    = 1'b0;
      we_s    = 1'b0;
      wdata_s = 8'h00;
      if (en_timer) begin
        case (t_q)
          T0: begin
            addr_s = pc_q;
            oe_s   = 1'b1;
          end
          T1: begin
            if (is_mvi_s | is_mem_s | is_jmp_s) begin
              addr_s = pc_q;
              oe_s   = 1'b1;
            end else begin
            end
          end
          T2: begin
            if (is_mem_s | is_jmp_s) begin
              addr_s = pc_q;
              oe_s   = 1'b1;
            end else begin
            end
          end
          T3: begin
            if (ir_q == OP_LDA) begin
              addr_s = mar_q;
              oe_s   = 1'b1;
            end else if (ir_q == OP_STA) begin
              addr_s  = mar_q;
              we_s    = 1'b1;
              wdata_s = a_q;
            end else begin
            end
          end
          default: begin
          end
        endcase
      end else begin
      end
    end

    // ALU result with carry/borrow in bit 8.
    always_comb begin
      alu_s = {1'b0, a_q};
      case (ir_q)
        OP_ADD:  alu_s = {1'b0, a_q} + {1'b0, b_q};
        OP_SUB:  alu_s = {1'b0, a_q} - {1'b0, b_q};
        OP_AND:  alu_s = {1'b0, a_q & b_q};
        OP_OR:   alu_s = {1'b0, a_q | b_q};
        OP_XOR:  alu_s = {1'b0, a_q ^ b_q};
        OP_NOT:  alu_s = {1'b0, ~a_q};
        default: alu_s = {1'b0, a_q};
      endcase
    end

    // Next-state sequencing per T-state and opcode; unknown opcodes fall through as NOP.
    always_comb begin
      a_d         = a_q;
      b_d         = b_q;
      ir_d        = ir_q;
      tmp_d       = tmp_q;
      pc_d        = pc_q;
      mar_d       = mar_q;
      z_d         = z_q;
      c_d         = c_q;
      t_d         = t_q;
      hlt_latch_d = HLT;
      if (en_timer) begin
        case (t_q)
          T0: begin
            ir_d = data_bus;
            pc_d = pc_q + 16'd1;
            t_d  = T1;
          end
          T1: begin
            t_d = T0;
            case (ir_q)
              OP_MVIA: begin
                a_d  = data_bus;
                pc_d = pc_q + 16'd1;
              end
              OP_MVIB: begin
                b_d  = data_bus;
                pc_d = pc_q + 16'd1;
              end
              OP_LDA, OP_STA: begin
                mar_d = {mar_q[15:8], data_bus};
                pc_d  = pc_q + 16'd1;
                t_d   = T2;
              end
              OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT: begin
                a_d = alu_s[7:0];
                c_d = alu_s[8];
                z_d = (alu_s[7:0] == 8'h00);
              end
              OP_MOVBA: b_d = a_q;
              OP_MOVAB: a_d = b_q;
              OP_JMP, OP_JZ, OP_JC: begin
                tmp_d = data_bus;
                pc_d  = pc_q + 16'd1;
                t_d   = T2;
              end
              OP_HLT:  hlt_latch_d = 1'b1;
              default: begin
              end
            endcase
          end
          T2: begin
            t_d = T0;
            if (is_mem_s) begin
              mar_d = {data_bus, mar_q[7:0]};
              pc_d  = pc_q + 16'd1;
              t_d   = T3;
            end else if (is_jmp_s) begin
              if (jump_taken_s) begin
                pc_d = {data_bus, tmp_q};
              end else begin
                pc_d = pc_q + 16'd1;
              end
            end else begin
            end
          end
          T3: begin
            t_d = T0;
            if (ir_q == OP_LDA) begin
              a_d = data_bus;
            end else begin
            end
          end
          default: t_d = T0;
        endcase
      end else begin
      end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
      if (!reset) begin
        a_q   <= 8'h00;
        b_q   <= 8'h00;
        ir_q  <= 8'h00;
        tmp_q <= 8'h00;
        pc_q  <= 16'h0000;
        mar_q <= 16'h0000;
        z_q   <= 1'b0;
        c_q   <= 1'b0;
        t_q   <= T0;
        HLT   <= 1'b0;
      end else begin
        a_q   <= a_d;
        b_q   <= b_d;
        ir_q  <= ir_d;
        tmp_q <= tmp_d;
        pc_q  <= pc_d;
        mar_q <= mar_d;
        z_q   <= z_d;
        c_q   <= c_d;
        t_q   <= t_d;
        HLT   <= hlt_latch_d;
      end
    end
  end

  if (1'b1) begin : RAM
    reg [7:0] mem [0:MEMORY_DEPTH-1];

    // Address bits 14:8 are ignored so the lower 32K mirrors the RAM.
    wire unused_addr_bits = &{1'b0, address_bus[14:8]};

    // Write port; the upper half of the address space is not backed.
    always_ff @(posedge clk) begin
      if (WE_M && !address_bus[15]) begin
        mem[address_bus[7:0]] <= data_bus;
      end
    end

    assign ram_rdata = address_bus[15] ? 8'h00 : mem[address_bus[7:0]];
  end

endmodule

// File: tb/tb_cpu.sv
module tb_cpu;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic hlt = 1'b0;

  always #5 clk = ~clk;

  cpu #(.MEMORY_DEPTH(256)) dut (
    .clk(clk),
    .reset(reset),
    .hlt(hlt)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  img [256];
  logic [15:0] f_addr = 16'h0000;
  logic [7:0]  f_data = 8'h00;

  // reference model state
  logic [7:0]  m_mem [256];
  logic [7:0]  m_a, m_b;
  logic        m_z, m_c;
  logic [15:0] m_pc;
  int          m_cyc;

  typedef struct {
    logic [7:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_a;
    logic       exp_z;
    logic       exp_c;
  } alu_vec_t;
  alu_vec_t vt [12];

  logic [7:0] prog1 [9]  = '{8'h10, 8'h05, 8'h11, 8'h03, 8'h30, 8'h21, 8'h80, 8'h00, 8'hFF};
  logic [7:0] prog2 [12] = '{8'h10, 8'hFF, 8'h11, 8'h01, 8'h30, 8'h51, 8'h09, 8'h00, 8'hFF, 8'h10, 8'hAA, 8'hFF};
  logic [7:0] prog3 [4]  = '{8'h20, 8'h10, 8'h00, 8'hFF};
  logic [7:0] prog4 [9]  = '{8'h10, 8'hFF, 8'h11, 8'h01, 8'h30, 8'h20, 8'h10, 8'h00, 8'hFF};
  logic [7:0] prog5 [9]  = '{8'h10, 8'h77, 8'h21, 8'h02, 8'h80, 8'h20, 8'h02, 8'h80, 8'hFF};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_img;
    for (int i = 0; i < 256; i++) img[i] = 8'h00;
  endtask

  // Write the whole image into RAM through forced buses while the core is held in reset.
  task automatic load_image;
    reset = 1'b0;
    hlt   = 1'b0;
    force dut.address_bus = f_addr;
    force dut.data_bus    = f_data;
    force dut.WE_M        = 1'b1;
    force dut.OE_M        = 1'b0;
    for (int i = 0; i < 256; i++) begin
      f_addr = 16'(i);
      f_data = img[i];
      tick(1);
    end
    release dut.address_bus;
    release dut.data_bus;
    release dut.WE_M;
    release dut.OE_M;
    tick(1);
  endtask

  task automatic start;
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
  endtask

  task automatic run_to_halt(input int budget, output int cyc);
    cyc = 0;
    while (dut.control_unit.HLT !== 1'b1 && cyc < budget) begin
      tick(1);
      cyc++;
      check("oe_we_exclusive", {31'd0, dut.OE_M & dut.WE_M}, 32'd0);
    end
    check("halt_reached", {31'd0, dut.control_unit.HLT}, 32'd1);
  endtask

  function automatic logic [7:0] m_rd(input logic [15:0] ad);
    return ad[15] ? 8'h00 : m_mem[ad[7:0]];
  endfunction

  // Instruction-level interpreter: one loop pass per instruction, cycles summed per class.
  task automatic model_run;
    logic [7:0]  op, lo, hi;
    logic [15:0] ea;
    int          s;
    bit          done;
    for (int i = 0; i < 256; i++) m_mem[i] = img[i];
    m_a = 8'h00; m_b = 8'h00; m_z = 1'b0; m_c = 1'b0; m_pc = 16'h0000; m_cyc = 0;
    done = 1'b0;
    for (int k = 0; k < 2000 && !done; k++) begin
      op = m_rd(m_pc);
      m_pc = m_pc + 16'd1;
      case (op)
        8'h10, 8'h11: begin
          if (op == 8'h10) m_a = m_rd(m_pc);
          else             m_b = m_rd(m_pc);
          m_pc = m_pc + 16'd1;
          m_cyc += 2;
        end
        8'h20, 8'h21: begin
          lo = m_rd(m_pc); m_pc = m_pc + 16'd1;
          hi = m_rd(m_pc); m_pc = m_pc + 16'd1;
          ea = {hi, lo};
          if (op == 8'h20) m_a = m_rd(ea);
          else if (!ea[15]) m_mem[ea[7:0]] = m_a;
          m_cyc += 4;
        end
        8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35: begin
          m_c = 1'b0;
          if (op == 8'h30) begin
            s = int'(m_a) + int'(m_b);
            m_c = (s > 255);
            m_a = 8'(s);
          end else if (op == 8'h31) begin
            m_c = (m_b > m_a);
            m_a = 8'(int'(m_a) - int'(m_b) + 256);
          end else if (op == 8'h32) m_a = m_a & m_b;
          else if (op == 8'h33) m_a = m_a | m_b;
          else if (op == 8'h34) m_a = m_a ^ m_b;
          else m_a = ~m_a;
          m_z = (m_a == 8'h00);
          m_cyc += 2;
        end
        8'h40: begin m_b = m_a; m_cyc += 2; end
        8'h41: begin m_a = m_b; m_cyc += 2; end
        8'h50, 8'h51, 8'h52: begin
          lo = m_rd(m_pc); m_pc = m_pc + 16'd1;
          hi = m_rd(m_pc); m_pc = m_pc + 16'd1;
          if (op == 8'h50 || (op == 8'h51 && m_z) || (op == 8'h52 && m_c)) m_pc = {hi, lo};
          m_cyc += 3;
        end
        8'hFF: begin m_cyc += 2; done = 1'b1; end
        default: m_cyc += 2;
      endcase
    end
  endtask

  task automatic gen_random;
    int pos;
    int k;
    for (int i = 0; i < 256; i++) img[i] = (i >= 192) ? 8'($urandom) : 8'h00;
    pos = 0;
    while (pos < 176) begin
      k = int'($urandom_range(0, 8));
      case (k)
        0, 1: begin
          img[pos] = (k == 0) ? 8'h10 : 8'h11;
          img[pos+1] = 8'($urandom);
          pos += 2;
        end
        2: begin img[pos] = 8'(8'h30 + $urandom_range(0, 5)); pos += 1; end
        3: begin img[pos] = ($urandom_range(0, 1) == 0) ? 8'h40 : 8'h41; pos += 1; end
        4, 5: begin
          img[pos]   = ($urandom_range(0, 1) == 0) ? 8'h20 : 8'h21;
          img[pos+1] = 8'($urandom_range(192, 255));
          img[pos+2] = 8'($urandom);
          pos += 3;
        end
        6: begin
          img[pos]   = 8'(8'h50 + $urandom_range(0, 2));
          img[pos+1] = 8'(pos + 4);
          img[pos+2] = 8'h00;
          img[pos+3] = 8'h35;
          pos += 4;
        end
        7: begin img[pos] = 8'($urandom_range(1, 15)); pos += 1; end
        default: begin img[pos] = 8'h30; pos += 1; end
      endcase
    end
    img[pos] = 8'hFF;
  endtask

  initial begin
    int cyc;

    vt[0]  = '{8'h30, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0};
    vt[1]  = '{8'h30, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};
    vt[2]  = '{8'h31, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b1};
    vt[3]  = '{8'h31, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0};
    vt[4]  = '{8'h32, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};
    vt[5]  = '{8'h33, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
    vt[6]  = '{8'h33, 8'hA0, 8'h05, 8'hA5, 1'b0, 1'b0};
    vt[7]  = '{8'h34, 8'hAA, 8'hAA, 8'h00, 1'b1, 1'b0};
    vt[8]  = '{8'h35, 8'h0F, 8'h77, 8'hF0, 1'b0, 1'b0};
    vt[9]  = '{8'h40, 8'h12, 8'h34, 8'h12, 1'b0, 1'b0};
    vt[10] = '{8'h41, 8'h12, 8'h34, 8'h34, 1'b0, 1'b0};
    vt[11] = '{8'h77, 8'h12, 8'h34, 8'h12, 1'b0, 1'b0};

    // reset state
    reset = 1'b0;
    tick(3);
    check("rst_pc", {16'd0, dut.control_unit.pc_q}, 32'd0);
    check("rst_t", {30'd0, dut.control_unit.t_q}, 32'd0);
    check("rst_hlt", {31'd0, dut.control_unit.HLT}, 32'd0);
    check("rst_a", {24'd0, dut.control_unit.a_q}, 32'd0);

    // table-driven ALU/MOV vectors: MVI A,a; MVI B,b; op; HLT
    for (int v = 0; v < 12; v++) begin
      clear_img();
      img[0] = 8'h10; img[1] = vt[v].a; img[2] = 8'h11; img[3] = vt[v].b;
      img[4] = vt[v].op; img[5] = 8'hFF;
      load_image();
      start();
      run_to_halt(20, cyc);
      check($sformatf("vec%0d_a", v), {24'd0, dut.control_unit.a_q}, {24'd0, vt[v].exp_a});
      check($sformatf("vec%0d_z", v), {31'd0, dut.control_unit.z_q}, {31'd0, vt[v].exp_z});
      check($sformatf("vec%0d_c", v), {31'd0, dut.control_unit.c_q}, {31'd0, vt[v].exp_c});
      check($sformatf("vec%0d_cyc", v), cyc, 32'd8);
    end

    // program 1: exact halt timing and store
    clear_img();
    for (int i = 0; i < 9; i++) img[i] = prog1[i];
    load_image();
    start();
    tick(11);
    check("p1_hlt_at11", {31'd0, dut.control_unit.HLT}, 32'd0);
    tick(1);
    check("p1_hlt_at12", {31'd0, dut.control_unit.HLT}, 32'd1);
    check("p1_a", {24'd0, dut.control_unit.a_q}, 32'h08);
    check("p1_mem80", {24'd0, dut.RAM.mem[8'h80]}, 32'h08);
    check("p1_z", {31'd0, dut.control_unit.z_q}, 32'd0);
    check("p1_c", {31'd0, dut.control_unit.c_q}, 32'd0);
    check("p1_pc", {16'd0, dut.control_unit.pc_q}, 32'h0009);
    tick(3);
    check("p1_pc_held", {16'd0, dut.control_unit.pc_q}, 32'h0009);

    // program 2: carry/zero and taken JZ
    clear_img();
    for (int i = 0; i < 12; i++) img[i] = prog2[i];
    load_image();
    start();
    run_to_halt(50, cyc);
    check("p2_cyc", cyc, 32'd13);
    check("p2_a", {24'd0, dut.control_unit.a_q}, 32'hAA);
    check("p2_z", {31'd0, dut.control_unit.z_q}, 32'd1);
    check("p2_c", {31'd0, dut.control_unit.c_q}, 32'd1);
    check("p2_pc", {16'd0, dut.control_unit.pc_q}, 32'h000C);

    // program 3: LDA timing
    clear_img();
    for (int i = 0; i < 4; i++) img[i] = prog3[i];
    img[8'h10] = 8'h5C;
    load_image();
    start();
    tick(3);
    check("p3_a_at3", {24'd0, dut.control_unit.a_q}, 32'h00);
    tick(1);
    check("p3_a_at4", {24'd0, dut.control_unit.a_q}, 32'h5C);
    tick(2);
    check("p3_hlt", {31'd0, dut.control_unit.HLT}, 32'd1);

    // LDA leaves flags set by a prior ADD
    clear_img();
    for (int i = 0; i < 9; i++) img[i] = prog4[i];
    img[8'h10] = 8'h5C;
    load_image();
    start();
    run_to_halt(40, cyc);
    check("p4_a", {24'd0, dut.control_unit.a_q}, 32'h5C);
    check("p4_z", {31'd0, dut.control_unit.z_q}, 32'd1);
    check("p4_c", {31'd0, dut.control_unit.c_q}, 32'd1);

    // STA/LDA above 0x7FFF
    clear_img();
    for (int i = 0; i < 9; i++) img[i] = prog5[i];
    load_image();
    start();
    run_to_halt(40, cyc);
    check("p5_cyc", cyc, 32'd12);
    check("p5_a", {24'd0, dut.control_unit.a_q}, 32'h00);
    check("p5_mem2", {24'd0, dut.RAM.mem[8'h02]}, 32'h21);

    // external stall in the middle of LDA
    clear_img();
    for (int i = 0; i < 4; i++) img[i] = prog3[i];
    img[8'h10] = 8'h5C;
    load_image();
    start();
    tick(2);
    hlt = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("stall_pc", {16'd0, dut.control_unit.pc_q}, 32'd2);
      check("stall_t", {30'd0, dut.control_unit.t_q}, 32'd2);
      check("stall_a", {24'd0, dut.control_unit.a_q}, 32'd0);
      check("stall_oe", {31'd0, dut.OE_M}, 32'd0);
      check("stall_we", {31'd0, dut.WE_M}, 32'd0);
    end
    hlt = 1'b0;
    tick(2);
    check("stall_a_done", {24'd0, dut.control_unit.a_q}, 32'h5C);
    tick(2);
    check("stall_hlt", {31'd0, dut.control_unit.HLT}, 32'd1);

    // direct RAM sweep through forced buses while the core is stalled
    hlt = 1'b1;
    force dut.address_bus = f_addr;
    force dut.data_bus    = f_data;
    force dut.WE_M        = 1'b1;
    force dut.OE_M        = 1'b0;
    for (int i = 0; i < 256; i++) begin
      f_addr = 16'(i);
      f_data = 8'(255 - i);
      tick(1);
    end
    f_addr = 16'h8003;
    f_data = 8'h00;
    tick(1);
    release dut.data_bus;
    force dut.WE_M = 1'b0;
    force dut.OE_M = 1'b1;
    for (int i = 0; i < 256; i++) begin
      f_addr = 16'(i);
      #1;
      check($sformatf("sweep_%0d", i), {24'd0, dut.data_bus}, 32'(255 - i));
    end
    f_addr = 16'h8005;
    #1;
    check("sweep_hi_read", {24'd0, dut.data_bus}, 32'd0);
    f_addr = 16'h4105;
    #1;
    check("sweep_mirror", {24'd0, dut.data_bus}, 32'(255 - 5));
    release dut.address_bus;
    release dut.WE_M;
    release dut.OE_M;
    hlt = 1'b0;
    tick(1);

    // reset during STA T2
    clear_img();
    for (int i = 0; i < 9; i++) img[i] = prog1[i];
    load_image();
    start();
    tick(8);
    check("rsta_t_before", {30'd0, dut.control_unit.t_q}, 32'd2);
    check("rsta_pc_before", {16'd0, dut.control_unit.pc_q}, 32'd7);
    reset = 1'b0;
    tick(1);
    check("rsta_pc", {16'd0, dut.control_unit.pc_q}, 32'd0);
    check("rsta_t", {30'd0, dut.control_unit.t_q}, 32'd0);
    check("rsta_a", {24'd0, dut.control_unit.a_q}, 32'd0);
    check("rsta_mem80", {24'd0, dut.RAM.mem[8'h80]}, 32'd0);
    reset = 1'b1;
    run_to_halt(40, cyc);
    check("rsta_cyc", cyc, 32'd12);
    check("rsta_mem80_after", {24'd0, dut.RAM.mem[8'h80]}, 32'h08);

    // random programs against the instruction-level model
    for (int r = 0; r < 25; r++) begin
      gen_random();
      model_run();
      load_image();
      start();
      run_to_halt(m_cyc + 10, cyc);
      check($sformatf("rnd%0d_cyc", r), cyc, m_cyc);
      check($sformatf("rnd%0d_a", r), {24'd0, dut.control_unit.a_q}, {24'd0, m_a});
      check($sformatf("rnd%0d_b", r), {24'd0, dut.control_unit.b_q}, {24'd0, m_b});
      check($sformatf("rnd%0d_z", r), {31'd0, dut.control_unit.z_q}, {31'd0, m_z});
      check($sformatf("rnd%0d_c", r), {31'd0, dut.control_unit.c_q}, {31'd0, m_c});
      check($sformatf("rnd%0d_pc", r), {16'd0, dut.control_unit.pc_q}, {16'd0, m_pc});
      for (int i = 192; i < 256; i++) begin
        check($sformatf("rnd%0d_mem%0h", r, i), {24'd0, dut.RAM.mem[i]}, {24'd0, m_mem[i]});
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cpu.md
# cpu

8-bit accumulator CPU with a 16-bit address bus and on-chip 256-byte RAM, executing a byte-coded program from address 0 after reset. It is the top-level compute block: a micro-sequenced control unit steps a timer through T-states and drives a shared 8-bit data bus, a 16-bit address bus and the RAM strobes. Benches and debug tooling rely on these hierarchy names: `RAM.mem`, `address_bus`, `data_bus`, `OE_M`, `WE_M`, `control_unit.HLT`, `control_unit.en_timer`.

## Interface
- `MEMORY_DEPTH`, 256: RAM bytes; `RAM.mem` is `reg [7:0] mem[0:MEMORY_DEPTH-1]`.
- `clk` input 1: single system clock, all state on rising edge.
- `reset` input 1: synchronous, active-low; held 0 clears state, released 1 starts execution.
- `hlt` input 1: external stall; while 1, no state changes, RAM strobes low.

## Operation
- Registers:
  - A, B (8b).
  - PC, MAR (16b).
  - IR (8b).
  - TMP (8b).
  - Flags Z, C.
  - T-state counter 0..3.
  - HLT latch.
- Internal nets `address_bus[15:0]`, `data_bus[7:0]`, `OE_M`, `WE_M` are plain wires so they can be forced.
- RAM:
  - Selected when `address_bus[15]==0`; indexes `address_bus[7:0]`, so the lower 32K mirrors.
  - Read is combinational onto `data_bus` when `OE_M`.
  - Write is on the rising edge when `WE_M`.
  - Addresses ≥0x8000: reads return 0x00, writes ignored.
- `control_unit.en_timer` = `reset & ~hlt & ~HLT`. When 0:
  - T-counter frozen.
  - No register writes.
  - OE_M = WE_M = 0.
  - Address/data buses undriven (0).
- Fetch (T0): address_bus=PC, OE_M=1; IR←data; PC←PC+1.
- Operand fetch cycles: address_bus=PC, OE_M; PC←PC+1.
- Opcodes; undefined opcodes execute as NOP:
  - 0x00 NOP.
  - 0x10 MVI A,imm: A←imm.
  - 0x11 MVI B,imm: B←imm.
  - 0x20 LDA lo,hi: A←mem[hi:lo].
  - 0x21 STA lo,hi: mem[hi:lo]←A.
  - 0x30 ADD: A←A+B, C=carry.
  - 0x31 SUB: A←A−B, C=borrow.
  - 0x32 AND, 0x33 OR, 0x34 XOR: A←A op B, C←0.
  - 0x35 NOT: A←~A, C←0.
  - 0x40 MOV B,A: B←A.
  - 0x41 MOV A,B: A←B.
  - 0x50 JMP lo,hi.
  - 0x51 JZ lo,hi: jump if Z.
  - 0x52 JC lo,hi: jump if C.
  - 0xFF HLT.
- Z is updated by ops 0x30–0x35 only (Z = result==0). LDA, MVI and MOV leave flags unchanged.
- Arithmetic is 8-bit, wrapping; PC wraps 0xFFFF→0x0000.
- HLT sets `control_unit.HLT`=1, held until reset. PC stays at HLT address + 1.

## Timing
- Reset (reset=0 at a rising edge):
  - PC=0, A=B=IR=TMP=0, MAR=0.
  - Z=C=0, T=0, HLT=0.
  - RAM contents not cleared.
- First fetch happens on the first rising edge with reset=1.
- Cycles per instruction (T0 included):
  - NOP/ALU/MOV/HLT: 2 (T1 executes).
  - MVI: 2 (T1 fetches imm into register).
  - JMP/JZ/JC: 3 (T1 TMP←lo; T2 PC←{hi,TMP} if taken, else operands consumed).
  - LDA/STA: 4 (T1 MAR[7:0]←lo; T2 MAR[15:8]←hi; T3 address_bus=MAR with OE_M→A or WE_M and data_bus=A).
- HLT rises at the end of its T1 edge.
- `hlt` input: sampled each edge; freezes the current T-state mid-instruction and resumes exactly where it stopped.
- Reset mid-instruction: abandons the instruction; state returns to reset values; no partial write beyond edges already taken.
- OE_M and WE_M are never both 1 from the CPU.

## Test plan
- Program `10 05 11 03 30 21 80 00 FF` -> A=0x08, mem[0x80]=0x08, HLT high after 2+2+2+4+2=12 cycles, Z=0 C=0.
- `10 FF 11 01 30 51 09 00 FF 10 AA FF` -> ADD gives A=0x00, C=1, Z=1; jump taken to 0x0009; final A=0xAA.
- `20 10 00 FF` with mem[0x10]=0x5C -> A=0x5C after 4 cycles, Z/C unchanged; also STA/LDA to 0x8002 -> ignored write, read 0x00.
- Raise `hlt` mid-LDA for 5 cycles -> PC/T/A frozen, OE_M=WE_M=0; completes normally after release.
- Force en_timer=0, sweep writes mem[i]=255−i via forced bus/WE_M, read back via forced OE_M -> all 256 match.
- reset=0 during STA T2 -> PC=0, T=0, memory unchanged, restarts from 0.
